// File: rtl/contador_ctrl_if.sv
// contador_ctrl_if -- control/status bundle between contador_ctrl and its user.
//   start, stop      : run request / abort request
//   dir, target      : run direction (0 up, 1 down) and terminal count
//   contador         : value fed back from the controlled 3-bit counter
//   chaves           : counter mode (00 up, 01 down, 10 clear, 11 hold)
//   tick             : one-cycle count enable
//   busy, done       : run in progress / one-cycle completion pulse
// master drives requests and the counter feedback; slave is the controller.
interface contador_ctrl_if;
    logic       start;
    logic       stop;
    logic       dir;
    logic [2:0] target;
    logic [2:0] contador;
    logic [1:0] chaves;
    logic       tick;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, dir, target, contador,
        input  chaves, tick, busy, done
    );

    modport slave (
        input  start, stop, dir, target, contador,
        output chaves, tick, busy, done
    );
endinterface

// File: rtl/contador_ctrl.sv
// contador_ctrl -- run controller for an external 3-bit up/down counter.
// Ports:
//   clock    : system clock, all state on the rising edge
//   reset_n  : synchronous active-low reset
//   bus      : contador_ctrl_if.slave (start/stop/dir/target/contador in,
//              chaves/tick/busy/done out)
// A run clears the counter, then issues one tick every PRESCALE cycles in
// the latched direction until the counter reads the latched target.
module contador_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    contador_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

    state_t     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic       dir_q, dir_d;
    logic [2:0] target_q, target_d;

    logic [1:0] chaves;
    logic       tick;
    logic       busy;
    logic       done;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            dir_q    <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dir_q    <= dir_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        dir_d    = dir_q;
        target_d = target_q;
        chaves   = 2'b11;
        tick     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    dir_d    = bus.dir;
                    target_d = bus.target;
                    state_d  = CLEAR;
                end
            end

            CLEAR: begin
                chaves  = 2'b10;
                busy    = 1'b1;
                state_d = bus.stop ? IDLE : RUN;
            end

            RUN: begin
                chaves = {1'b0, dir_q};
                busy   = 1'b1;
                // Priority: stop, then target match, then prescaler.
                // The prescaler only advances while the run continues,
                // so it is zero again on the first cycle of the next run.
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.contador == target_q) begin
                    state_d = DONE;
                end else begin
                    tick    = (presc_q == PRESC_MAX);
                    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 8'd1;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.chaves = chaves;
    assign bus.tick   = tick;
    assign bus.busy   = busy;
    assign bus.done   = done;

endmodule

// File: tb/tb_contador_ctrl.sv
// tb_contador_ctrl -- directed bench for contador_ctrl.
// Two instances: dut_a (PRESCALE=4) and dut_b (PRESCALE=1), each driving a
// behavioural 3-bit counter that presets to 0 (up run) or 7 (down run) on
// clear. Inputs change 1 ns after the rising edge; outputs are checked on
// the falling edge of the same cycle.
module tb_contador_ctrl;

    logic clk;
    logic rst_n;

    contador_ctrl_if bus_a ();
    contador_ctrl_if bus_b ();

    contador_ctrl #(.PRESCALE(4)) dut_a (.clock(clk), .reset_n(rst_n), .bus(bus_a));
    contador_ctrl #(.PRESCALE(1)) dut_b (.clock(clk), .reset_n(rst_n), .bus(bus_b));

    // {chaves, tick, busy, done}
    localparam logic [7:0] O_IDLE = 8'h18;
    localparam logic [7:0] O_CLR  = 8'h12;
    localparam logic [7:0] O_UP   = 8'h02;
    localparam logic [7:0] O_UPT  = 8'h06;
    localparam logic [7:0] O_DN   = 8'h0A;
    localparam logic [7:0] O_DNT  = 8'h0E;
    localparam logic [7:0] O_DONE = 8'h19;

    int n_assert = 0;
    int n_fail   = 0;

    logic       pre_a, pre_b;
    logic [2:0] cnt_a, cnt_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled counters.
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt_a <= 3'd0;
            cnt_b <= 3'd0;
        end else begin
            if (bus_a.chaves == 2'b10)
                cnt_a <= pre_a ? 3'd7 : 3'd0;
            else if (bus_a.tick && bus_a.chaves == 2'b00)
                cnt_a <= cnt_a + 3'd1;
            else if (bus_a.tick && bus_a.chaves == 2'b01)
                cnt_a <= cnt_a - 3'd1;

            if (bus_b.chaves == 2'b10)
                cnt_b <= pre_b ? 3'd7 : 3'd0;
            else if (bus_b.tick && bus_b.chaves == 2'b00)
                cnt_b <= cnt_b + 3'd1;
            else if (bus_b.tick && bus_b.chaves == 2'b01)
                cnt_b <= cnt_b - 3'd1;
        end
    end

    assign bus_a.contador = cnt_a;
    assign bus_b.contador = cnt_b;

    function automatic logic [7:0] obs(input bit sel);
        if (sel)
            return {3'b000, bus_b.chaves, bus_b.tick, bus_b.busy, bus_b.done};
        return {3'b000, bus_a.chaves, bus_a.tick, bus_a.busy, bus_a.done};
    endfunction

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle with the given inputs applied to the selected instance.
    task automatic apply(input bit sel, input logic rst, input logic st,
                         input logic sp, input logic d, input logic [2:0] tg);
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus_a.start   = sel ? 1'b0 : st;
        bus_a.stop    = sel ? 1'b0 : sp;
        bus_a.dir     = sel ? 1'b0 : d;
        bus_a.target  = sel ? 3'd0 : tg;
        bus_b.start   = sel ? st : 1'b0;
        bus_b.stop    = sel ? sp : 1'b0;
        bus_b.dir     = sel ? d : 1'b0;
        bus_b.target  = sel ? tg : 3'd0;
        if (st && !sp) begin
            if (sel) pre_b = d;
            else     pre_a = d;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit sel);
        apply(sel, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // Up-run cycles c_from..c_to on dut_a (counter starts at 0, one tick
    // every 4th RUN cycle until the counter equals tgt).
    task automatic run_up(input int c_from, input int c_to, input int tgt, input string tag);
        for (int c = c_from; c <= c_to; c++) begin
            int exp_cnt;
            idle(1'b0);
            exp_cnt = (c - 1) / 4;
            chk($sformatf("%s_out_c%0d", tag, c), obs(1'b0),
                ((c % 4 == 0) && (exp_cnt != tgt)) ? O_UPT : O_UP);
            chk($sformatf("%s_cnt_c%0d", tag, c), {5'b0, cnt_a}, 8'(exp_cnt));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pre_a = 1'b0;
        pre_b = 1'b0;
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.dir = 1'b0; bus_a.target = 3'd0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.dir = 1'b0; bus_b.target = 3'd0;

        // Reset state
        apply(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        apply(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("reset_a", obs(1'b0), O_IDLE);
        chk("reset_b", obs(1'b1), O_IDLE);

        // Reset overrides start
        apply(0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
        idle(0);
        chk("rst_over_start", obs(1'b0), O_IDLE);

        // Up run to 3, PRESCALE=4: ticks at RUN cycles 4, 8, 12
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        chk("r28_idle", obs(1'b0), O_IDLE);
        idle(0);
        chk("r28_clear", obs(1'b0), O_CLR);
        run_up(1, 13, 3, "r28");
        idle(0);
        chk("r28_done", obs(1'b0), O_DONE);
        idle(0);
        chk("r28_back_idle", obs(1'b0), O_IDLE);
        chk("r28_cnt_final", {5'b0, cnt_a}, 8'd3);

        // Down run to 5, PRESCALE=1: counter 7, 6, 5 and two ticks
        apply(1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
        idle(1);
        chk("r29_clear", obs(1'b1), O_CLR);
        idle(1);
        chk("r29_c1", obs(1'b1), O_DNT);
        chk("r29_c1_cnt", {5'b0, cnt_b}, 8'd7);
        idle(1);
        chk("r29_c2", obs(1'b1), O_DNT);
        chk("r29_c2_cnt", {5'b0, cnt_b}, 8'd6);
        idle(1);
        chk("r29_c3", obs(1'b1), O_DN);
        chk("r29_c3_cnt", {5'b0, cnt_b}, 8'd5);
        idle(1);
        chk("r29_done", obs(1'b1), O_DONE);
        idle(1);
        chk("r29_idle", obs(1'b1), O_IDLE);
        chk("r29_cnt_final", {5'b0, cnt_b}, 8'd5);

        // Target equal to post-clear value: zero ticks
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        idle(0);
        chk("r30_clear", obs(1'b0), O_CLR);
        idle(0);
        chk("r30_run", obs(1'b0), O_UP);
        idle(0);
        chk("r30_done", obs(1'b0), O_DONE);
        idle(0);
        chk("r30_idle", obs(1'b0), O_IDLE);
        chk("r30_cnt", {5'b0, cnt_a}, 8'd0);

        // Stop at RUN cycle 5
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        idle(0);
        chk("r31_clear", obs(1'b0), O_CLR);
        run_up(1, 4, 2, "r31");
        apply(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("r31_stop_cycle", obs(1'b0), O_UP);
        idle(0);
        chk("r31_idle", obs(1'b0), O_IDLE);
        idle(0);
        chk("r31_no_done", obs(1'b0), O_IDLE);
        chk("r31_cnt_frozen", {5'b0, cnt_a}, 8'd1);

        // Stop on the prescaler terminal cycle suppresses the tick
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        idle(0);
        run_up(1, 3, 2, "stp4");
        apply(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("stp4_no_tick", obs(1'b0), O_UP);
        idle(0);
        chk("stp4_idle", obs(1'b0), O_IDLE);
        chk("stp4_cnt", {5'b0, cnt_a}, 8'd0);

        // Stop during CLEAR
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        apply(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3);
        chk("stpclr_clear", obs(1'b0), O_CLR);
        idle(0);
        chk("stpclr_idle", obs(1'b0), O_IDLE);

        // start+stop together in IDLE
        apply(0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
        chk("r32_ss_cycle", obs(1'b0), O_IDLE);
        idle(0);
        chk("r32_ss_stay", obs(1'b0), O_IDLE);

        // start with new dir/target during RUN is ignored
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        idle(0);
        chk("r32_clear", obs(1'b0), O_CLR);
        run_up(1, 1, 2, "r32");
        apply(0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7);
        chk("r32_restart_ign", obs(1'b0), O_UP);
        run_up(3, 9, 2, "r32");
        idle(0);
        chk("r32_done", obs(1'b0), O_DONE);
        idle(0);
        chk("r32_idle", obs(1'b0), O_IDLE);
        chk("r32_cnt", {5'b0, cnt_a}, 8'd2);

        // Reset mid-RUN, then a normal run
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        idle(0);
        run_up(1, 6, 3, "r33");
        apply(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("r33_rst_cycle", obs(1'b0), O_UP);
        idle(0);
        chk("r33_after_rst", obs(1'b0), O_IDLE);
        idle(0);
        chk("r33_no_done", obs(1'b0), O_IDLE);
        apply(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
        idle(0);
        chk("r33_clear", obs(1'b0), O_CLR);
        run_up(1, 5, 1, "r33b");
        idle(0);
        chk("r33_done", obs(1'b0), O_DONE);
        idle(0);
        chk("r33_idle", obs(1'b0), O_IDLE);
        chk("r33_cnt", {5'b0, cnt_a}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
